// File: rtl/radio_tx_arbiter_if.sv
// Signal bundle between the two packet generators, the radio TX byte loader and the arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface radio_tx_arbiter_if;
    logic [1:0] req;
    logic [1:0] gnt;
    logic [1:0] rdy;
    logic       wr0;
    logic       wr1;
    logic [7:0] data0;
    logic [7:0] data1;
    logic [1:0] fire;
    logic       ld_ready;
    logic [7:0] ld_data;
    logic       ld_wr;
    logic       tx_fire;
    logic       tx_done;
    logic       tx_abort;
    logic       busy;
    logic [2:0] dbg_state;

    // Byte handshake: a requester may raise wrN only while rdy[N] is high, and drops it
    // after rdy[N] falls; each rising edge of the owner's wrN is exactly one byte.
    modport slave (
        input  req, wr0, wr1, data0, data1, fire, ld_ready, tx_done,
        output gnt, rdy, ld_data, ld_wr, tx_fire, tx_abort, busy, dbg_state
    );

    modport master (
        output req, wr0, wr1, data0, data1, fire, ld_ready, tx_done,
        input  gnt, rdy, ld_data, ld_wr, tx_fire, tx_abort, busy, dbg_state
    );
endinterface

// File: rtl/radio_tx_arbiter.sv
// Round-robin arbiter sharing the radio TX byte loader between two packet generators,
// holding the grant for a whole packet until the radio reports done, with load/TX watchdogs.
module radio_tx_arbiter #(
    parameter int LOAD_TIMEOUT = 4096,
    parameter int TX_TIMEOUT   = 65535,
    parameter int MAX_BYTES    = 128
) (
    input  logic                 clk,
    input  logic                 reset,
    radio_tx_arbiter_if.slave    bus
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_GRANT     = 3'd1,
        S_LOAD      = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_RELEASE   = 3'd4
    } state_t;

    localparam logic [16:0] LOAD_TO = 17'(LOAD_TIMEOUT);
    localparam logic [16:0] TX_TO   = 17'(TX_TIMEOUT);
    localparam logic [8:0]  MAX_B   = 9'(MAX_BYTES);

    state_t      r_state;
    logic        r_owner;
    logic        r_last_owner;
    logic [1:0]  r_gnt;
    logic [7:0]  r_byte_cnt;
    logic [15:0] r_wdog;
    logic        r_wr_prev;
    logic [7:0]  r_ld_data;
    logic        r_ld_wr;
    logic        r_tx_fire;
    logic        r_tx_abort;
    logic        r_busy;

    logic        w_own_wr;
    logic [7:0]  w_own_data;
    logic        w_own_fire;
    logic        w_own_req;
    logic        w_rise;
    logic        w_pick;
    logic [16:0] w_wdog_inc;
    logic [15:0] w_wdog_sat;
    logic        w_load_to;
    logic        w_tx_to;
    logic        w_cnt_over;

    assign w_own_wr   = r_owner ? bus.wr1 : bus.wr0;
    assign w_own_data = r_owner ? bus.data1 : bus.data0;
    assign w_own_fire = bus.fire[r_owner];
    assign w_own_req  = bus.req[r_owner];
    assign w_rise     = w_own_wr & ~r_wr_prev;
    // Contention goes to whoever did not own the loader last.
    assign w_pick     = (bus.req == 2'b11) ? ~r_last_owner : bus.req[1];
    assign w_wdog_inc = {1'b0, r_wdog} + 17'd1;
    assign w_wdog_sat = (r_wdog == 16'hFFFF) ? r_wdog : w_wdog_inc[15:0];
    assign w_load_to  = (w_wdog_inc == LOAD_TO);
    assign w_tx_to    = (w_wdog_inc == TX_TO);
    assign w_cnt_over = w_rise && (({1'b0, r_byte_cnt} + 9'd1) > MAX_B);

    assign bus.gnt       = r_gnt;
    assign bus.rdy       = r_gnt & {2{bus.ld_ready && (r_state == S_LOAD)}};
    assign bus.ld_data   = r_ld_data;
    assign bus.ld_wr     = r_ld_wr;
    assign bus.tx_fire   = r_tx_fire;
    assign bus.tx_abort  = r_tx_abort;
    assign bus.busy      = r_busy;
    assign bus.dbg_state = r_state;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_gnt        <= 2'b00;
            r_byte_cnt   <= 8'd0;
            r_wdog       <= 16'd0;
            r_wr_prev    <= 1'b0;
            r_ld_data    <= 8'd0;
            r_ld_wr      <= 1'b0;
            r_tx_fire    <= 1'b0;
            r_tx_abort   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_tx_fire  <= 1'b0;
            r_tx_abort <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_ld_wr <= 1'b0;
                    if (|bus.req) begin
                        r_owner <= w_pick;
                        r_gnt   <= w_pick ? 2'b10 : 2'b01;
                        r_busy  <= 1'b1;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_byte_cnt <= 8'd0;
                    r_wdog     <= 16'd0;
                    r_wr_prev  <= 1'b0;
                    r_state    <= S_LOAD;
                end
                S_LOAD: begin
                    r_ld_data <= w_own_data;
                    r_ld_wr   <= w_own_wr;
                    r_wr_prev <= w_own_wr;
                    if (w_rise) begin
                        r_byte_cnt <= r_byte_cnt + 8'd1;
                        r_wdog     <= 16'd0;
                    end else begin
                        r_wdog <= w_wdog_sat;
                    end
                    // A fire that coincides with a stall expiry still wins: the packet is complete.
                    if (!w_own_req || w_cnt_over) begin
                        r_ld_wr    <= 1'b0;
                        r_tx_abort <= 1'b1;
                        r_state    <= S_RELEASE;
                    end else if (w_own_fire) begin
                        r_tx_fire <= 1'b1;
                        r_wdog    <= 16'd0;
                        r_state   <= S_WAIT_DONE;
                    end else if (!w_rise && w_load_to) begin
                        r_ld_wr    <= 1'b0;
                        r_tx_abort <= 1'b1;
                        r_state    <= S_RELEASE;
                    end
                end
                S_WAIT_DONE: begin
                    r_ld_wr <= 1'b0;
                    if (bus.tx_done) begin
                        r_state <= S_RELEASE;
                    end else if (w_tx_to) begin
                        r_tx_abort <= 1'b1;
                        r_state    <= S_RELEASE;
                    end else begin
                        r_wdog <= w_wdog_sat;
                    end
                end
                S_RELEASE: begin
                    r_ld_wr      <= 1'b0;
                    r_gnt        <= 2'b00;
                    r_last_owner <= r_owner;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_gnt   <= 2'b00;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_radio_tx_arbiter.sv
// Directed bench for radio_tx_arbiter: grant order, byte pass-through, fire/done, watchdogs,
// byte-count overflow and mid-packet reset, with hand-computed expectations.
module tb_radio_tx_arbiter;
    localparam int ST_IDLE  = 0;
    localparam int ST_GRANT = 1;
    localparam int ST_LOAD  = 2;
    localparam int ST_WAIT  = 3;
    localparam int ST_REL   = 4;

    logic clk;
    logic reset;
    logic mon_en;
    int   n_checks;
    int   n_errors;

    radio_tx_arbiter_if bus();

    radio_tx_arbiter #(
        .LOAD_TIMEOUT(16),
        .TX_TIMEOUT  (100),
        .MAX_BYTES   (128)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input int who, input logic [7:0] d);
        if (who == 0) begin
            bus.wr0   = 1'b1;
            bus.data0 = d;
        end else begin
            bus.wr1   = 1'b1;
            bus.data1 = d;
        end
        step();
        chk("ld_wr_hi", 32'(bus.ld_wr), 1);
        chk("ld_data", 32'(bus.ld_data), 32'(d));
        bus.wr0 = 1'b0;
        bus.wr1 = 1'b0;
        step();
        chk("ld_wr_lo", 32'(bus.ld_wr), 0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("gnt_onehot0", 32'($onehot0(bus.gnt)), 1);
            chk("fire_abort_excl", 32'(bus.tx_fire & bus.tx_abort), 0);
        end
    end

    initial begin
        logic [7:0] pkt [11];
        int own;
        logic [1:0] exp_g;
        pkt = '{8'h0B, 8'hC1, 8'h88, 8'h7D, 8'h22, 8'h00, 8'hFE, 8'hFF, 8'h05, 8'h00, 8'h3C};
        n_checks     = 0;
        n_errors     = 0;
        mon_en       = 1'b0;
        reset        = 1'b1;
        bus.req      = 2'b00;
        bus.wr0      = 1'b0;
        bus.wr1      = 1'b0;
        bus.data0    = 8'h00;
        bus.data1    = 8'h00;
        bus.fire     = 2'b00;
        bus.ld_ready = 1'b1;
        bus.tx_done  = 1'b0;
        step();
        step();
        mon_en = 1'b1;
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_rdy", 32'(bus.rdy), 0);
        chk("rst_ld_data", 32'(bus.ld_data), 0);
        chk("rst_ld_wr", 32'(bus.ld_wr), 0);
        chk("rst_tx_fire", 32'(bus.tx_fire), 0);
        chk("rst_tx_abort", 32'(bus.tx_abort), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_state", 32'(bus.dbg_state), ST_IDLE);

        // Single requester, 11-byte packet, tx_done 50 cycles after fire
        reset   = 1'b0;
        bus.req = 2'b01;
        step();
        chk("s1_gnt", 32'(bus.gnt), 1);
        chk("s1_busy", 32'(bus.busy), 1);
        chk("s1_state_grant", 32'(bus.dbg_state), ST_GRANT);
        step();
        chk("s1_rdy", 32'(bus.rdy), 1);
        bus.ld_ready = 1'b0;
        #1;
        chk("s1_rdy_ldready_lo", 32'(bus.rdy), 0);
        bus.ld_ready = 1'b1;
        for (int i = 0; i < 11; i++) send_byte(0, pkt[i]);
        bus.fire = 2'b01;
        step();
        chk("s1_tx_fire", 32'(bus.tx_fire), 1);
        chk("s1_state_wait", 32'(bus.dbg_state), ST_WAIT);
        bus.fire = 2'b00;
        bus.req  = 2'b00;
        step();
        chk("s1_tx_fire_pulse", 32'(bus.tx_fire), 0);
        chk("s1_gnt_held", 32'(bus.gnt), 1);
        chk("s1_rdy_wait", 32'(bus.rdy), 0);
        repeat (48) step();
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        chk("s1_state_rel", 32'(bus.dbg_state), ST_REL);
        chk("s1_gnt_rel", 32'(bus.gnt), 1);
        chk("s1_no_abort", 32'(bus.tx_abort), 0);
        step();
        chk("s1_gnt_off", 32'(bus.gnt), 0);
        chk("s1_busy_off", 32'(bus.busy), 0);

        // Both requesting from reset: grants alternate 0,1,0,1,0,1
        reset = 1'b1;
        step();
        reset   = 1'b0;
        bus.req = 2'b11;
        for (int p = 0; p < 6; p++) begin
            own   = p % 2;
            exp_g = (own == 0) ? 2'b01 : 2'b10;
            step();
            chk("s2_gnt", 32'(bus.gnt), 32'(exp_g));
            step();
            chk("s2_rdy", 32'(bus.rdy), 32'(exp_g));
            send_byte(own, 8'hA0 + 8'(p));
            send_byte(own, 8'h50 + 8'(p));
            bus.fire = exp_g;
            step();
            chk("s2_tx_fire", 32'(bus.tx_fire), 1);
            bus.fire = 2'b00;
            if (p >= 4) bus.req[own] = 1'b0;
            step();
            chk("s2_gnt_wait", 32'(bus.gnt), 32'(exp_g));
            bus.tx_done = 1'b1;
            step();
            bus.tx_done = 1'b0;
            chk("s2_gnt_rel", 32'(bus.gnt), 32'(exp_g));
            step();
            chk("s2_gap", 32'(bus.gnt), 0);
        end

        // Load stall: owner 0 stops after 5 bytes, requester 1 pending
        bus.req = 2'b11;
        step();
        chk("s3_gnt0", 32'(bus.gnt), 1);
        step();
        for (int i = 0; i < 5; i++) send_byte(0, 8'h10 + 8'(i));
        repeat (14) step();
        chk("s3_no_abort_early", 32'(bus.tx_abort), 0);
        chk("s3_still_load", 32'(bus.dbg_state), ST_LOAD);
        step();
        chk("s3_abort", 32'(bus.tx_abort), 1);
        chk("s3_ld_wr", 32'(bus.ld_wr), 0);
        chk("s3_state_rel", 32'(bus.dbg_state), ST_REL);
        step();
        chk("s3_abort_pulse", 32'(bus.tx_abort), 0);
        chk("s3_idle", 32'(bus.dbg_state), ST_IDLE);
        step();
        chk("s3_gnt1_next", 32'(bus.gnt), 2);
        bus.req = 2'b10;

        // Overflow: owner 1 writes 129 bytes
        step();
        for (int i = 0; i < 128; i++) send_byte(1, 8'(i));
        bus.wr1   = 1'b1;
        bus.data1 = 8'hEE;
        step();
        chk("s4_abort", 32'(bus.tx_abort), 1);
        chk("s4_byte_dropped", 32'(bus.ld_wr), 0);
        chk("s4_state_rel", 32'(bus.dbg_state), ST_REL);
        bus.wr1 = 1'b0;
        bus.req = 2'b00;
        step();
        chk("s4_gnt_off", 32'(bus.gnt), 0);
        chk("s4_busy_off", 32'(bus.busy), 0);

        // TX timeout: no tx_done within 100 cycles of tx_fire
        bus.req = 2'b01;
        step();
        chk("s5_gnt", 32'(bus.gnt), 1);
        step();
        send_byte(0, 8'h0B);
        bus.fire = 2'b01;
        step();
        chk("s5_tx_fire", 32'(bus.tx_fire), 1);
        bus.fire = 2'b00;
        bus.req  = 2'b00;
        repeat (99) step();
        chk("s5_no_abort_99", 32'(bus.tx_abort), 0);
        chk("s5_wait_99", 32'(bus.dbg_state), ST_WAIT);
        step();
        chk("s5_abort_100", 32'(bus.tx_abort), 1);
        chk("s5_rel", 32'(bus.dbg_state), ST_REL);
        step();
        chk("s5_gnt_off", 32'(bus.gnt), 0);

        // tx_done exactly at the timeout cycle, fire coincident with the last byte
        bus.req = 2'b01;
        step();
        chk("s5b_gnt", 32'(bus.gnt), 1);
        step();
        bus.wr0   = 1'b1;
        bus.data0 = 8'h5A;
        bus.fire  = 2'b01;
        step();
        chk("s5b_ld_wr", 32'(bus.ld_wr), 1);
        chk("s5b_ld_data", 32'(bus.ld_data), 32'h5A);
        chk("s5b_tx_fire", 32'(bus.tx_fire), 1);
        bus.wr0  = 1'b0;
        bus.fire = 2'b00;
        bus.req  = 2'b00;
        step();
        chk("s5b_ld_wr_wait", 32'(bus.ld_wr), 0);
        repeat (98) step();
        bus.tx_done = 1'b1;
        step();
        bus.tx_done = 1'b0;
        chk("s5b_no_abort", 32'(bus.tx_abort), 0);
        chk("s5b_rel", 32'(bus.dbg_state), ST_REL);
        step();
        chk("s5b_gnt_off", 32'(bus.gnt), 0);

        // Reset in the middle of a load
        bus.req = 2'b10;
        step();
        chk("s6_gnt", 32'(bus.gnt), 2);
        step();
        for (int i = 0; i < 3; i++) send_byte(1, 8'hC0 + 8'(i));
        bus.wr1   = 1'b1;
        bus.data1 = 8'h77;
        reset     = 1'b1;
        step();
        chk("s6_gnt_rst", 32'(bus.gnt), 0);
        chk("s6_ld_wr_rst", 32'(bus.ld_wr), 0);
        chk("s6_abort_rst", 32'(bus.tx_abort), 0);
        chk("s6_busy_rst", 32'(bus.busy), 0);
        chk("s6_state_rst", 32'(bus.dbg_state), ST_IDLE);
        reset   = 1'b0;
        bus.wr1 = 1'b0;
        bus.req = 2'b11;
        step();
        chk("s6_gnt0_first", 32'(bus.gnt), 1);
        bus.req = 2'b00;
        mon_en  = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/radio_tx_arbiter.md
Name: radio_tx_arbiter

Overview:
- Shares the single radio TX byte-loader (idx control byte interface plus tx fire) between two packet generators, e.g. the audio packet generator and a sensor/data packet generator.
- Grants the loader to one requester for a whole packet, using round-robin.
- Passes that requester's byte handshake through, forwards its fire request, and holds the grant until the radio reports transmission done.
- Watchdogs abort stalled loads and transmissions.

Parameters:
- LOAD_TIMEOUT, 4096: max cycles between consecutive bytes (or grant-to-first-byte) in LOAD before abort.
- TX_TIMEOUT, 65535: max cycles from tx_fire to tx_done before abort.
- MAX_BYTES, 128: max bytes per packet (length byte + 127); the byte that takes the count above MAX_BYTES causes abort.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  2  per-requester packet request; level, held until the requester's fire
- gnt  out  2  one-hot grant; 0 when no owner
- rdy  out  2  per-requester ready: ld_ready & gnt[i] & (state==LOAD)
- wr0, wr1  in  1 each  requester byte strobe (raised when rdy is high, dropped after rdy falls)
- data0, data1  in  8 each  requester byte
- fire  in  2  requester 1-cycle "packet loaded" pulse
- ld_ready  in  1  loader ready from radio ctrl; drops after accepting a byte
- ld_data  out  8  registered byte to idx control
- ld_wr  out  1  registered byte strobe to idx control
- tx_fire  out  1  1-cycle start-transmission pulse to radio
- tx_done  in  1  radio transmission complete pulse
- tx_abort  out  1  1-cycle pulse: radio ctrl flushes its TX buffer
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values: gnt=0, rdy=0, ld_data=0, ld_wr=0, tx_fire=0, tx_abort=0, busy=0, state=IDLE, last_owner=1 (so requester 0 wins first), byte_cnt=0, wdog=0.
- Reset asserted in any state returns to IDLE next edge; any partial packet is dropped with no abort pulse.
- States: IDLE, GRANT, LOAD, WAIT_DONE, RELEASE.
- IDLE:
  - If any req bit is set, pick the owner.
  - Only one request: that requester wins.
  - Both requesting: the requester not equal to last_owner wins.
  - Register gnt (one-hot) and go to GRANT. gnt rises 1 cycle after req is sampled.
- GRANT:
  - Clear byte_cnt and wdog; go to LOAD. First rdy is possible 2 cycles after req.
- LOAD:
  - ld_data <= data of owner and ld_wr <= wr of owner, every cycle (1-cycle pipeline).
  - A non-owner's wr, data and fire are ignored.
  - On a rising edge of owner wr: byte_cnt++ and wdog<=0; otherwise wdog++.
  - Owner fire: tx_fire pulses 1 cycle on the next edge; go to WAIT_DONE; wdog<=0.
  - fire in the same cycle as a wr rising edge: the byte is still forwarded and counted.
  - fire with byte_cnt==0 is still honoured (an empty packet is the generator's problem).
  - Abort conditions, each giving tx_abort pulse and RELEASE:
    - byte_cnt would exceed MAX_BYTES;
    - wdog reaches LOAD_TIMEOUT;
    - owner req drops before fire.
  - On abort, ld_wr is forced 0 on the same edge.
- WAIT_DONE:
  - ld_wr=0 and rdy=0; gnt stays held so the owner cannot start its next packet.
  - tx_done: go to RELEASE.
  - wdog reaches TX_TIMEOUT: tx_abort pulse, then RELEASE.
  - tx_done in the same cycle as timeout expiry: treat as done, no abort.
  - tx_done seen in any other state is ignored.
- RELEASE:
  - gnt <= 0; last_owner <= owner; go to IDLE.
  - Arbitration restarts the next cycle, giving a minimum 1-cycle gap between owners.
- Counters:
  - wdog is 16 bits, saturating; byte_cnt is 8 bits.
  - Comparisons are unsigned. LOAD_TIMEOUT and TX_TIMEOUT must be at most 65535.
- Invariants: gnt is always one-hot or zero, and tx_fire and tx_abort never assert in the same cycle.

Test Plan:
- req=01, owner loads 11 bytes (length 0x0B, C1 88 7D 22 00 FE FF 05 00, 1 payload byte) then fire, then tx_done after 50 cycles -> gnt=01 one cycle after req; ld_data sequence matches, each 1 cycle delayed; tx_fire one pulse; gnt=00 2 cycles after tx_done.
- req=11 from reset, both hold req for 3 packets each -> grants alternate 0,1,0,1,0,1; each grant persists through WAIT_DONE; no overlap of gnt bits.
- Owner 0 stops after 5 bytes with LOAD_TIMEOUT=16 -> tx_abort pulses 16 cycles after the 5th byte edge, ld_wr=0, state returns to IDLE, requester 1 (pending) granted next.
- Owner 1 writes 129 bytes with MAX_BYTES=128 -> the 129th wr edge triggers tx_abort; that byte is not forwarded on ld_wr.
- Fire issued, tx_done never arrives, TX_TIMEOUT=100 -> tx_abort at cycle 100 after tx_fire; second run with tx_done exactly at cycle 100 -> no abort, normal release.
- Reset asserted mid-LOAD after 3 bytes -> next cycle gnt=0, ld_wr=0, tx_abort=0, busy=0; subsequent req=11 grants requester 0 first.
